// File: rtl/pair_capture_fifo.sv
// rtl/pair_capture_fifo.sv - pair capture FIFO with rotate-XOR signature of accepted pairs
module pair_capture_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [W-1:0]             Ain,
  input  logic [W-1:0]             Bin,
  input  logic                     Avalid,
  output logic                     Aready,
  output logic [2*W-1:0]           Dout,
  output logic                     Dvalid,
  input  logic                     Dready,
  input  logic                     Clear,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [2*W-1:0]           Sig
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [2*W-1:0] mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           push;
  logic           pop;

  // Handshake outputs decode from registered occupancy only.
  assign Aready = (Count != FULL);
  assign Dvalid = (Count != '0);
  assign Dout   = mem[rptr];

  assign push = Avalid && Aready && !Clear;
  assign pop  = Dvalid && Dready && !Clear;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr] <= {Ain, Bin};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr  <= '0;
      rptr  <= '0;
      Count <= '0;
      Sig   <= '0;
    end else if (Clear) begin
      wptr  <= '0;
      rptr  <= '0;
      Count <= '0;
      Sig   <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
        Sig  <= {Sig[2*W-2:0], Sig[2*W-1]} ^ {Ain, Bin};
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   Count <= Count + (AW+1)'(1);
        2'b01:   Count <= Count - (AW+1)'(1);
        default: Count <= Count;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_capture_fifo.sv
// tb/tb_pair_capture_fifo.sv - directed scoreboard bench for pair_capture_fifo
module tb_pair_capture_fifo;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [7:0]  Ain, Bin;
  logic        Avalid, Aready;
  logic [15:0] Dout;
  logic        Dvalid, Dready, Clear;
  logic [2:0]  Count;
  logic [15:0] Sig;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];
  int          mcount;
  logic [15:0] msig;

  pair_capture_fifo #(.W(8), .DEPTH(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .Ain(Ain), .Bin(Bin), .Avalid(Avalid),
    .Aready(Aready), .Dout(Dout), .Dvalid(Dvalid), .Dready(Dready),
    .Clear(Clear), .Count(Count), .Sig(Sig)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(Count), 32'(mcount));
    check({tag, "_dvalid"}, 32'(Dvalid), 32'(mcount != 0));
    check({tag, "_aready"}, 32'(Aready), 32'(mcount != 4));
    check({tag, "_sig"}, 32'(Sig), 32'(msig));
  endtask

  // Called at a negedge: drives one cycle of stimulus, predicts, and checks at the next negedge.
  task automatic step(input logic av, input logic [7:0] a, input logic [7:0] b,
                      input logic dr, input logic clr, input string tag);
    logic do_push, do_pop;
    Avalid = av; Ain = a; Bin = b; Dready = dr; Clear = clr;
    do_push = av && (mcount != 4) && !clr;
    do_pop  = dr && (mcount != 0) && !clr;
    check({tag, "_aready_pre"}, 32'(Aready), 32'(mcount != 4));
    if (do_pop) begin
      check({tag, "_dout"}, 32'(Dout), 32'(q[0]));
      void'(q.pop_front());
    end
    @(posedge CLK);
    if (clr) begin
      q.delete();
      mcount = 0;
      msig = '0;
    end else begin
      if (do_push) begin
        q.push_back({a, b});
        msig = {msig[14:0], msig[15]} ^ {a, b};
      end
      mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
    @(negedge CLK);
    Avalid = 1'b0; Dready = 1'b0; Clear = 1'b0;
    check_state(tag);
  endtask

  initial begin
    RSTn = 1'b0; Ain = '0; Bin = '0; Avalid = 1'b0; Dready = 1'b0; Clear = 1'b0;
    mcount = 0; msig = '0;
    repeat (2) @(negedge CLK);
    check_state("reset");
    RSTn = 1'b1;
    @(negedge CLK);

    step(1'b1, 8'd67, 8'd111, 1'b0, 1'b0, "single_push");
    check("single_dout", 32'(Dout), 32'h436F);
    check("single_sig", 32'(Sig), 32'h436F);
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, "single_pop");

    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, "clr0");
    step(1'b1, 8'd67, 8'd111, 1'b0, 1'b0, "chain1");
    step(1'b1, 8'd147, 8'd25, 1'b0, 1'b0, "chain2");
    check("chain_sig", 32'(Sig), 32'h15C7);
    check("chain_count", 32'(Count), 32'd2);
    check("chain_head", 32'(Dout), 32'h436F);
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, "chain_pop1");
    check("chain_head2", 32'(Dout), 32'h9319);
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, "chain_pop2");

    for (int i = 0; i < 4; i++) step(1'b1, 8'(2*i+1), 8'(2*i+2), 1'b0, 1'b0, "fill");
    check("full_count", 32'(Count), 32'd4);
    check("full_aready", 32'(Aready), 32'd0);
    step(1'b1, 8'hEE, 8'hEE, 1'b0, 1'b0, "no_fifth");
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, "wrap_pop");
    step(1'b1, 8'd152, 8'd223, 1'b0, 1'b0, "wrap_push");
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, "drain");
    check("wrap_last", 32'(Dout), 32'h98DF);
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, "drain_last");

    for (int i = 0; i < 4; i++) step(1'b1, 8'(16+i), 8'(32+i), 1'b0, 1'b0, "refill");
    step(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, "full_pop");
    check("full_pop_count", 32'(Count), 32'd3);
    step(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, "push_pop");
    check("push_pop_count", 32'(Count), 32'd3);

    check("clear_sig_nonzero", 32'(Sig != 16'h0), 32'd1);
    step(1'b1, 8'd55, 8'd66, 1'b0, 1'b1, "clear");
    check("clear_count", 32'(Count), 32'd0);
    check("clear_sig", 32'(Sig), 32'd0);
    step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, "post_clear_push");
    check("post_clear_dout", 32'(Dout), 32'h1234);
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, "post_clear_pop");

    step(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, "pre_rst1");
    step(1'b1, 8'h03, 8'h04, 1'b0, 1'b0, "pre_rst2");
    #1 RSTn = 1'b0;
    #1;
    q.delete(); mcount = 0; msig = '0;
    check_state("async_rst");
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    check_state("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
